// File: rtl/load_store_buffer_unit.sv
// Load/store unit with a posted store buffer in front of an internal
// synchronous data memory. Tagged requests arrive over valid/ready; stores
// respond immediately and drain later; loads wait out any buffered store to
// the same word before reading.
//
// Ports:
//   clk, reset (async, active-low)
//   req_*        : request handshake, operation, size, extension, operands, tag
//   mem_busy     : stalls store-buffer drain
//   flush        : kills the in-flight load (HAZARD/READ)
//   resp_*       : one-cycle tagged response pulse
//   sb_count     : occupied store-buffer entries
//   idle         : FSM idle and store buffer empty
module load_store_buffer_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned SB_DEPTH  = 4,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_load,
  input  logic                        req_is_store,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [XLEN-1:0]             rs1_data,
  input  logic [XLEN-1:0]             rs2_data,
  input  logic [XLEN-1:0]             imm,
  input  logic [TAG_W-1:0]            req_tag,
  input  logic                        mem_busy,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [TAG_W-1:0]            resp_tag,
  output logic [XLEN-1:0]             resp_data,
  output logic                        resp_is_store,
  output logic                        resp_misaligned,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        idle
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HAZARD, READ} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [3:0]       mask;
    logic [XLEN-1:0]  data;
  } sb_entry_t;

  state_t           state_q, state_d;
  sb_entry_t        sb_q [SB_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  mem [MEM_WORDS];

  logic [IDX_W-1:0] ld_idx_q;
  logic [1:0]       ld_lane_q;
  logic [1:0]       ld_size_q;
  logic             ld_uns_q;
  logic [TAG_W-1:0] ld_tag_q;

  logic [XLEN-1:0]  addr;
  logic [IDX_W-1:0] widx;
  logic             op_load, op_store, fault;
  logic             accept, enq, drain, sb_full, match;
  logic [IDX_W-1:0] key;
  logic [3:0]       st_mask;
  logic [XLEN-1:0]  st_data;
  logic             unused_addr;

  assign addr        = rs1_data + imm;
  assign widx        = addr[IDX_W+1:2];
  assign unused_addr = ^addr[XLEN-1:IDX_W+2];
  assign op_load     = req_is_load & ~req_is_store;
  assign op_store    = req_is_store & ~req_is_load;

  // Alignment / legality check
  always_comb begin
    fault = ~(op_load | op_store);
    case (req_size)
      2'b00:   ;
      2'b01:   if (addr[0]) fault = 1'b1;
      2'b10:   if (addr[1:0] != 2'b00) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  // Fullness from the registered count: a same-cycle drain does not free a slot
  assign sb_full   = (cnt_q == CNT_W'(SB_DEPTH));
  assign req_ready = (state_q == IDLE) && !(req_is_store && sb_full);
  assign accept    = req_valid && req_ready;
  assign enq       = accept && op_store && !fault;
  assign drain     = (cnt_q != '0) && !mem_busy;
  assign idle      = (state_q == IDLE) && (cnt_q == '0);
  assign sb_count  = cnt_q;

  // Byte-lane placement of store data
  always_comb begin
    case (req_size)
      2'b00:   st_mask = 4'b0001 << addr[1:0];
      2'b01:   st_mask = 4'b0011 << addr[1:0];
      default: st_mask = 4'b1111;
    endcase
    st_data = rs2_data << {addr[1:0], 3'b000};
  end

  // Word-index match against occupied buffer entries (masks ignored)
  always_comb begin
    logic [PTR_W-1:0] off;
    off   = '0;
    match = 1'b0;
    key   = (state_q == IDLE) ? widx : ld_idx_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      off = PTR_W'(i) - head_q;
      if ((CNT_W'(off) < cnt_q) && (sb_q[i].idx == key)) match = 1'b1;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && op_load && !fault) state_d = match ? HAZARD : READ;
      HAZARD:  if (flush) state_d = IDLE;
               else if (!match) state_d = READ;
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Captured load context
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_idx_q  <= '0;
      ld_lane_q <= '0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      ld_tag_q  <= '0;
    end else if (accept && op_load && !fault) begin
      ld_idx_q  <= widx;
      ld_lane_q <= addr[1:0];
      ld_size_q <= req_size;
      ld_uns_q  <= req_unsigned;
      ld_tag_q  <= req_tag;
    end
  end

  // Store-buffer pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Store-buffer payload
  always_ff @(posedge clk) begin
    if (enq) sb_q[tail_q] <= '{idx: widx, mask: st_mask, data: st_data};
  end

  // Drain head entry into memory under its byte mask
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_q[head_q].mask[b])
          mem[sb_q[head_q].idx][8*b +: 8] <= sb_q[head_q].data[8*b +: 8];
      end
    end
  end

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                              input logic [1:0] lane,
                                              input logic [1:0] size,
                                              input logic uns);
    logic [XLEN-1:0] sh;
    sh = w >> {lane, 3'b000};
    case (size)
      2'b00:   return uns ? XLEN'(sh[7:0])  : {{(XLEN-8){sh[7]}},  sh[7:0]};
      2'b01:   return uns ? XLEN'(sh[15:0]) : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Response register: store/fault responses at T+1, load data after READ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid      <= 1'b0;
      resp_tag        <= '0;
      resp_data       <= '0;
      resp_is_store   <= 1'b0;
      resp_misaligned <= 1'b0;
    end else begin
      resp_valid      <= 1'b0;
      resp_tag        <= '0;
      resp_data       <= '0;
      resp_is_store   <= 1'b0;
      resp_misaligned <= 1'b0;
      if (accept && (op_store || fault)) begin
        resp_valid      <= 1'b1;
        resp_tag        <= req_tag;
        resp_is_store   <= op_store;
        resp_misaligned <= fault;
      end else if (state_q == READ && !flush) begin
        resp_valid <= 1'b1;
        resp_tag   <= ld_tag_q;
        resp_data  <= extract(mem[ld_idx_q], ld_lane_q, ld_size_q, ld_uns_q);
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer_unit.sv
module tb_load_store_buffer_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_load;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [5:0]  req_tag;
  logic        mem_busy;
  logic        flush;
  logic        resp_valid;
  logic [5:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_is_store;
  logic        resp_misaligned;
  logic [2:0]  sb_count;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  load_store_buffer_unit #(
    .XLEN(32), .TAG_W(6), .SB_DEPTH(4), .MEM_WORDS(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .req_tag(req_tag),
    .mem_busy(mem_busy), .flush(flush),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
    .resp_is_store(resp_is_store), .resp_misaligned(resp_misaligned),
    .sb_count(sb_count), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic ld, input logic st, input logic [1:0] size,
                         input logic uns, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] off,
                         input logic [5:0] tag);
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_is_store = st;
    req_size     = size;
    req_unsigned = uns;
    rs1_data     = rs1;
    rs2_data     = rs2;
    imm          = off;
    req_tag      = tag;
  endtask

  task automatic idle_req();
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
  endtask

  task automatic chk_resp(input string name, input logic v, input logic [5:0] tag,
                          input logic [31:0] data, input logic st, input logic mis);
    chk({name, ".valid"}, resp_valid, v);
    chk({name, ".tag"}, resp_tag, tag);
    chk({name, ".data"}, resp_data, data);
    chk({name, ".is_store"}, resp_is_store, st);
    chk({name, ".misaligned"}, resp_misaligned, mis);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && !idle; i++) step();
    chk(name, idle, 1);
  endtask

  task automatic do_load(input string name, input logic uns, input logic [1:0] size,
                         input logic [31:0] rs1, input logic [31:0] off,
                         input logic [5:0] tag, input logic [31:0] exp);
    set_req(1'b1, 1'b0, size, uns, rs1, 32'h0, off, tag);
    step();
    idle_req();
    chk({name, ".read_noresp"}, resp_valid, 0);
    step();
    chk_resp(name, 1'b1, tag, exp, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    mem_busy = 1'b0;
    flush    = 1'b0;
    idle_req();
    req_size = 2'b00; req_unsigned = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; req_tag = '0;

    // Reset state
    #3;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.idle", idle, 1);
    chk("rst.sb_count", sb_count, 0);
    chk_resp("rst", 1'b0, 6'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word store then word load
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 32'h10, 6'd1);
    chk("st_word.ready", req_ready, 1);
    step();
    idle_req();
    chk_resp("st_word", 1'b1, 6'd1, 32'h0, 1'b1, 1'b0);
    chk("st_word.cnt1", sb_count, 1);
    step();
    chk("st_word.cnt0", sb_count, 0);
    chk("st_word.resp_gone", resp_valid, 0);
    do_load("lw0", 1'b0, 2'b10, 32'h0, 32'h10, 6'd2, 32'hDEADBEEF);

    // Byte store and sub-word loads
    set_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF, 32'h1, 6'd3);
    step();
    idle_req();
    chk_resp("st_byte", 1'b1, 6'd3, 32'h0, 1'b1, 1'b0);
    wait_idle("st_byte.drained");
    do_load("lb_s", 1'b0, 2'b00, 32'h10, 32'h1, 6'd4, 32'hFFFFFFFF);
    do_load("lbu", 1'b1, 2'b00, 32'h10, 32'h1, 6'd5, 32'h000000FF);
    do_load("lw1", 1'b0, 2'b10, 32'h10, 32'h0, 6'd6, 32'hDEADFFEF);
    do_load("lh_s", 1'b0, 2'b01, 32'h10, 32'h0, 6'd7, 32'hFFFFFFEF);

    // Buffer full under mem_busy, then drain
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 6'(8 + i));
      chk("fill.ready", req_ready, 1);
      step();
      chk("fill.resp", resp_valid, 1);
      chk("fill.cnt", sb_count, 32'(i + 1));
    end
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h104, 32'h0, 6'd12);
    chk("full.ready", req_ready, 0);
    step();
    chk("full.noresp", resp_valid, 0);
    chk("full.cnt", sb_count, 4);
    mem_busy = 1'b0;
    step();
    chk("drain.cnt3", sb_count, 3);
    chk("drain.ready", req_ready, 1);
    step();
    idle_req();
    chk_resp("st5", 1'b1, 6'd12, 32'h0, 1'b1, 1'b0);
    chk("st5.cnt", sb_count, 3);
    step();
    chk("drain.cnt2", sb_count, 2);
    step();
    chk("drain.cnt1", sb_count, 1);
    step();
    chk("drain.cnt0", sb_count, 0);
    do_load("lw_drained", 1'b0, 2'b10, 32'h40, 32'hC, 6'd13, 32'h00000103);

    // Load hazard on a buffered word
    mem_busy = 1'b1;
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 6'd14);
    step();
    idle_req();
    chk("haz.cnt1", sb_count, 1);
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 6'd15);
    chk("haz.ready_in", req_ready, 1);
    step();
    idle_req();
    chk("haz.noresp0", resp_valid, 0);
    chk("haz.ready", req_ready, 0);
    chk("haz.idle", idle, 0);
    step();
    chk("haz.noresp1", resp_valid, 0);
    mem_busy = 1'b0;
    step();
    chk("haz.cnt0", sb_count, 0);
    chk("haz.noresp2", resp_valid, 0);
    step();
    chk("haz.read_noresp", resp_valid, 0);
    step();
    chk_resp("haz_ld", 1'b1, 6'd15, 32'h12345678, 1'b0, 1'b0);

    // Faults: no memory effect
    set_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h3, 6'd20);
    step();
    chk_resp("mis_half", 1'b1, 6'd20, 32'h0, 1'b0, 1'b1);
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hAAAAAAAA, 32'h2, 6'd21);
    step();
    chk("mis_st.valid", resp_valid, 1);
    chk("mis_st.tag", resp_tag, 21);
    chk("mis_st.data", resp_data, 0);
    chk("mis_st.misaligned", resp_misaligned, 1);
    chk("mis_st.cnt", sb_count, 0);
    set_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 6'd22);
    step();
    chk_resp("size11", 1'b1, 6'd22, 32'h0, 1'b0, 1'b1);
    set_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hBBBBBBBB, 32'h0, 6'd23);
    step();
    idle_req();
    chk_resp("both_set", 1'b1, 6'd23, 32'h0, 1'b0, 1'b1);
    chk("both_set.cnt", sb_count, 0);
    do_load("lw_unchanged", 1'b0, 2'b10, 32'h10, 32'h0, 6'd24, 32'hDEADFFEF);

    // Flush during HAZARD
    mem_busy = 1'b1;
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h55, 32'h0, 6'd25);
    step();
    set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 6'd26);
    step();
    idle_req();
    chk("flush.in_hazard", req_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.ready", req_ready, 1);
    chk("flush.noresp0", resp_valid, 0);
    step();
    chk("flush.noresp1", resp_valid, 0);
    chk("flush.sb_kept", sb_count, 1);

    // Asynchronous reset with buffered stores
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h34, 32'h66, 32'h0, 6'd27);
    step();
    set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h38, 32'h77, 32'h0, 6'd28);
    step();
    idle_req();
    chk("pre_rst.cnt", sb_count, 3);
    chk("pre_rst.resp", resp_valid, 1);
    mem_busy = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_rst.cnt", sb_count, 0);
    chk("async_rst.resp", resp_valid, 0);
    chk("async_rst.idle", idle, 1);
    chk("async_rst.ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_buffer_unit.md
Name: load_store_buffer_unit

Overview:
Parametrised successor to the single-cycle load/store unit. It accepts tagged load and store requests over a valid/ready handshake and supports byte, half and word sizes with signed or unsigned load extension. Stores are posted into a SB_DEPTH-entry store buffer that drains into an internal synchronous data memory; a load that hits a buffered word is held until that word has drained. Results return tagged for broadcast on the out-of-order core's result bus.

Parameters:
XLEN, 32, data/address width
TAG_W, 6, width of the ROB/result tag
SB_DEPTH, 4, store buffer entries (power of two, >=2)
MEM_WORDS, 1024, internal memory depth in XLEN words (power of two)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit accepts request this cycle
req_is_load  in  1  load request
req_is_store  in  1  store request (exactly one of load/store set when req_valid)
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (else sign-extend)
rs1_data  in  XLEN  base address
rs2_data  in  XLEN  store data (low bytes used)
imm  in  XLEN  offset
req_tag  in  TAG_W  tag returned with the response
mem_busy  in  1  blocks store-buffer drain this cycle
flush  in  1  synchronous kill of the in-flight load
resp_valid  out  1  response valid, one-cycle pulse
resp_tag  out  TAG_W  tag of the responding request
resp_data  out  XLEN  extended load data; 0 for stores and faults
resp_is_store  out  1  response belongs to a store
resp_misaligned  out  1  request faulted; no memory effect
sb_count  out  clog2(SB_DEPTH)+1  occupied store-buffer entries
idle  out  1  FSM in IDLE and sb_count==0

Behaviour:
- Reset (reset=0, asynchronous): every output is 0 except req_ready=1 and idle=1. FSM goes to IDLE, the buffer is emptied and a pending response is dropped. Memory contents are not reset. Reset mid-drain loses all buffered stores.
- Address: addr = rs1_data + imm, modulo 2^XLEN. Word index = addr[clog2(MEM_WORDS)+1:2], which wraps modulo MEM_WORDS.
- Faults: size 11, half with addr[0]=1, or word with addr[1:0]!=0. The request is accepted and responds one cycle later with resp_misaligned=1 and resp_data=0. There is no buffer or memory effect.
- FSM states: IDLE, HAZARD, READ.
  - req_ready = (state==IDLE) and not (req_is_store and buffer full). Fullness uses the registered count, so a drain in the same cycle does not free a slot.
- Store accept:
  - Enqueue {word index, 4-bit byte mask, data shifted to its byte lane}.
  - Response at T+1 with resp_is_store=1 and resp_data=0.
  - FSM stays in IDLE.
- Drain: each cycle with buffer non-empty and mem_busy=0, the head entry is written to memory under its byte mask and popped. Enqueue and drain in the same cycle leave sb_count unchanged.
- Load accept in IDLE:
  - If any valid buffer entry has the same word index (masks ignored), go to HAZARD; otherwise go to READ.
  - HAZARD re-evaluates the match every cycle and moves to READ once no entry matches.
  - READ issues the synchronous memory read, then returns to IDLE.
  - resp_valid is asserted the cycle after READ. Latency is exactly 2 cycles from accept when there is no hazard.
  - Data extraction: byte lane addr[1:0], half lane addr[1]. Extend per req_unsigned. Word data is passed through.
- Response ordering: at most one response per cycle. A store accepted in the IDLE cycle that carries a load response responds on the following cycle, so there is no collision.
- flush=1 in HAZARD or READ: return to IDLE and suppress that load's response. flush=1 in IDLE has no effect. The buffer is never flushed.
- Load and store both set, or neither set, with req_valid=1: treated as an illegal fault, same as size 11.

Test Plan:
- Store word 0xDEADBEEF (rs1=0, imm=0x10) -> resp_valid and resp_is_store at T+1; sb_count goes 1 then 0. Load word at 0x10 (no hazard) -> resp_data=0xDEADBEEF at T+2 with matching tag.
- Store byte 0xFF at 0x11, then:
  - load signed byte -> 0xFFFFFFFF
  - load unsigned byte -> 0x000000FF
  - load word at 0x10 -> 0xDEADFFEF
  - load signed half at 0x10 -> 0xFFFFFFEF
- mem_busy=1 and 5 stores offered back-to-back -> 4 accepted, req_ready=0 on the 5th, sb_count=4. Release mem_busy -> sb_count falls one per cycle and the 5th store is then accepted.
- mem_busy=1, store 0x12345678 at 0x20, then load word at 0x20 -> FSM in HAZARD, no resp. Release mem_busy -> resp_data=0x12345678 two cycles after HAZARD exits.
- Half load at 0x13, and word store at 0x12 -> each gives resp_misaligned=1 and resp_data=0 next cycle. Memory is unchanged (a later word load at 0x10 returns the prior value).
- flush during HAZARD -> no response and req_ready=1 next cycle. reset low during drain with sb_count=3 -> sb_count=0, resp_valid=0 and idle=1 immediately, without waiting for a clock edge.
